// File: rtl/queue_ram_pkg.sv
// Shared helpers for the queue RAM and the queue wrappers built on it.
// Address widths are derived here so every wrapper sizes its ports the same way.
package queue_ram_pkg;

    // ceil(log2(value)), never below one bit so a single-word RAM still has a port
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value)
            r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Simple-dual-port word RAM for queue entries: one write port, one registered read port.
// The array holds only plain synchronous accesses; bypass and zeroing sit behind it.
module queue_ram
    import queue_ram_pkg::*;
#(
    parameter int elementWidth = 32,
    parameter int elementCount = 8,
    parameter int depth        = 256,
    parameter int addrWidth    = clog2_min1(depth)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [elementWidth-1:0] data [elementCount],
    input  logic [addrWidth-1:0]    write_addr,
    input  logic [addrWidth-1:0]    read_addr,
    input  logic                    we,
    output logic [elementWidth-1:0] q [elementCount]
);

    localparam int                 WORD_W  = elementWidth * elementCount;
    localparam logic [addrWidth:0] DEPTH_L = (addrWidth + 1)'(depth);

    logic [WORD_W-1:0] r_mem [depth];
    logic [WORD_W-1:0] r_rd_word;
    logic [WORD_W-1:0] r_bypass_word;
    logic              r_bypass;
    logic              r_valid;

    logic [WORD_W-1:0] w_data_word;
    logic [WORD_W-1:0] w_q_word;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_en;

    always_comb begin
        w_data_word = '0;
        for (int i = 0; i < elementCount; i++)
            w_data_word[i*elementWidth +: elementWidth] = data[i];
    end

    // Addresses past the last word (non-power-of-two depth) never touch the array
    assign w_wr_in_range = ({1'b0, write_addr} < DEPTH_L);
    assign w_rd_in_range = ({1'b0, read_addr} < DEPTH_L);
    assign w_wr_en       = !reset && we && w_wr_in_range;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[write_addr] <= w_data_word;
    end

    always_ff @(posedge clk) begin
        r_rd_word <= r_mem[read_addr];
    end

    always_ff @(posedge clk) begin
        r_bypass_word <= w_data_word;
    end

    // r_valid low forces q to zero: after reset, or when the read address was out of range
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_bypass <= 1'b0;
        end else begin
            r_valid  <= w_rd_in_range;
            r_bypass <= we && (read_addr == write_addr);
        end
    end

    always_comb begin
        if (!r_valid)
            w_q_word = '0;
        else if (r_bypass)
            w_q_word = r_bypass_word;
        else
            w_q_word = r_rd_word;
    end

    always_comb begin
        for (int i = 0; i < elementCount; i++)
            q[i] = w_q_word[i*elementWidth +: elementWidth];
    end

endmodule

// File: tb/tb_queue_ram.sv
// Scoreboard bench for queue_ram: a full-depth instance and a depth-200 instance share stimulus.
// Expected words come from a behavioural memory model per instance.
module tb_queue_ram;

    logic       clk;
    logic       reset;
    logic [7:0] data [8];
    logic [7:0] write_addr;
    logic [7:0] read_addr;
    logic       we;
    logic [7:0] q1 [8];
    logic [7:0] q2 [8];
    logic [63:0] q1_w, q2_w;

    queue_ram #(.elementWidth(8), .elementCount(8), .depth(256)) dut (
        .clk(clk), .reset(reset), .data(data), .write_addr(write_addr),
        .read_addr(read_addr), .we(we), .q(q1)
    );

    queue_ram #(.elementWidth(8), .elementCount(8), .depth(200)) dut_d200 (
        .clk(clk), .reset(reset), .data(data), .write_addr(write_addr),
        .read_addr(read_addr), .we(we), .q(q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        q1_w = '0;
        q2_w = '0;
        for (int i = 0; i < 8; i++) begin
            q1_w[i*8 +: 8] = q1[i];
            q2_w[i*8 +: 8] = q2[i];
        end
    end

    typedef struct {
        string       tag;
        bit          chk1;
        logic [63:0] e1;
        bit          chk2;
        logic [63:0] e2;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] m_mem [2][256];
    bit          m_vld [2][256];
    int          dep [2] = '{256, 200};
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [63:0] seq_word();
        logic [63:0] w;
        for (int i = 0; i < 8; i++)
            w[i*8 +: 8] = 8'(i + 1);
        return w;
    endfunction

    // One clock: drive inputs, push the expected q, then pop and compare after the edge
    task automatic cyc(input string tag, input bit rst, input bit w, input int wa,
                       input logic [63:0] wd, input int ra);
        exp_t e;
        bit          c [2];
        logic [63:0] x [2];
        reset      = rst;
        we         = w;
        write_addr = 8'(wa);
        read_addr  = 8'(ra);
        for (int i = 0; i < 8; i++)
            data[i] = wd[i*8 +: 8];
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                x[k] = '0; c[k] = 1'b1;
            end else if (ra >= dep[k]) begin
                x[k] = '0; c[k] = 1'b1;
            end else if (w && wa == ra) begin
                x[k] = wd; c[k] = 1'b1;
            end else begin
                x[k] = m_mem[k][ra]; c[k] = m_vld[k][ra];
            end
            if (!rst && w && wa < dep[k]) begin
                m_mem[k][wa] = wd;
                m_vld[k][wa] = 1'b1;
            end
        end
        e.tag = tag; e.chk1 = c[0]; e.e1 = x[0]; e.chk2 = c[1]; e.e2 = x[1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk1) check(e.tag, q1_w, e.e1);
        if (e.chk2) check({e.tag, "_d200"}, q2_w, e.e2);
    endtask

    initial begin
        logic [63:0] rnd;
        reset = 1'b1; we = 1'b0; write_addr = '0; read_addr = '0;
        for (int i = 0; i < 8; i++) data[i] = '0;

        cyc("reset0", 1, 0, 0, 64'h0, 0);
        cyc("reset1", 1, 0, 0, 64'h0, 0);

        cyc("wr5", 0, 1, 5, seq_word(), 0);
        cyc("rd5", 0, 0, 0, 64'h0, 5);

        cyc("wt9", 0, 1, 9, rep(8'hAA), 9);

        cyc("wr3", 0, 1, 3, rep(8'h11), 0);
        cyc("rd3_wr4", 0, 1, 4, rep(8'h22), 3);
        cyc("rd4", 0, 0, 0, 64'h0, 4);

        cyc("wr255", 0, 1, 255, 64'hFEDC_BA98_7654_3210, 5);
        cyc("wr0", 0, 1, 0, 64'h0123_4567_89AB_CDEF, 255);
        cyc("rd255", 0, 0, 0, 64'h0, 255);
        cyc("rd0", 0, 0, 0, 64'h0, 0);
        cyc("wr199", 0, 1, 199, 64'hC7C7_0000_1111_C7C7, 3);
        cyc("wr200", 0, 1, 200, 64'hC8C8_2222_3333_C8C8, 199);
        cyc("rd200", 0, 0, 0, 64'h0, 200);
        cyc("wt210", 0, 1, 210, 64'hD2D2_D2D2_5555_6666, 210);
        cyc("rd0b", 0, 0, 0, 64'h0, 0);

        cyc("wr7", 0, 1, 7, 64'h7777_0000_7777_0001, 5);
        cyc("rd7", 0, 0, 0, 64'h0, 7);
        cyc("rst_wr7", 1, 1, 7, 64'hBAD0_BAD0_BAD0_BAD0, 7);
        cyc("rd7_post", 0, 0, 0, 64'h0, 7);
        cyc("rd5_post", 0, 0, 0, 64'h0, 5);
        cyc("rd3_post", 0, 0, 0, 64'h0, 3);

        for (int n = 0; n < 10; n++) begin
            rnd = {$urandom, $urandom};
            cyc("hold4", 0, 0, 4, rnd, 4);
        end

        for (int n = 0; n < 60; n++) begin
            int wa, ra;
            wa  = ($urandom_range(0, 7) == 0) ? 230 : int'($urandom_range(20, 27));
            ra  = ($urandom_range(0, 7) == 0) ? 230 : int'($urandom_range(20, 27));
            rnd = {$urandom, $urandom};
            cyc("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, wa, rnd, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
